cosim_commit_queue: RTL and testbench
=====================================

Name: cosim_commit_queue

Overview:
- Captures per-cycle retirement events from one hart's commit stage and buffers them in order.
- Also captures external-interrupt (mip) changes and queues them in the same ordered stream.
- Presents queued events one at a time to the Spike co-simulation checker over a valid/ready handshake.
- Sits between the core commit interface and the DPI step/compare logic, so a slow checker never loses an event.

Parameters:
- DEPTH, 16, queue entries; power of two, minimum 4.
- HART_ID, 0, hart index echoed on the output for DPI hart selection.
- AFULL_SLACK, 2, almost_full_o asserts when free entries are at or below this value.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- commit_valid_i  in  1  one instruction retires this cycle
- commit_pc_i  in  64  PC of retired instruction
- commit_ins_i  in  32  instruction word
- commit_we_i  in  1  register write valid
- commit_dst_i  in  6  destination; bit5=FP file
- commit_data_i  in  64  write data
- commit_xcpt_i  in  1  instruction raised exception
- commit_cause_i  in  64  exception cause
- mip_i  in  64  core external-interrupt pending vector
- out_valid_o  out  1  head event available
- out_ready_i  in  1  checker consumes head
- out_kind_o  out  1  0=commit, 1=mip update
- out_pc_o  out  64  commit PC; 0 for mip events
- out_ins_o  out  32  instruction word
- out_we_o  out  1  write valid
- out_dst_o  out  6  destination
- out_data_o  out  64  commit data; new mip value for mip events
- out_xcpt_o  out  1  exception flag
- out_cause_o  out  64  cause
- out_seq_o  out  32  event sequence number
- out_hart_o  out  32  HART_ID
- count_o  out  log2(DEPTH)+1  occupancy
- almost_full_o  out  1  backpressure hint to commit stage
- overflow_o  out  1  sticky; event dropped

Behaviour:
- Reset (async, rst_n low):
  - all outputs 0 except out_hart_o=HART_ID;
  - read/write pointers and count 0; seq counter 0; overflow_o 0;
  - mip shadow register 0.
  - Deassertion mid-operation discards all queued contents.
- mip detection:
  - mip_change = (mip_i != mip_shadow), evaluated every cycle.
  - Shadow updates to mip_i only when the mip event is enqueued.
- Enqueue per cycle, 0, 1 or 2 events:
  - Commit event when commit_valid_i.
  - Mip event when mip_change.
  - When both occur, commit is written at wptr and mip at wptr+1. Commit precedes mip because the interrupt applies to the next instruction.
- Sequence numbers:
  - Each enqueued event takes the next seq value; the counter wraps modulo 2^32.
  - Seq advances only for events actually written.
- Space rule (free = DEPTH - count + pop, where pop = out_valid_o & out_ready_i in the same cycle):
  - Both events need free >= 2. If free == 1, commit is written, mip is deferred with the shadow unchanged (no overflow), and it retries next cycle.
  - A commit with free == 0 is dropped and sets overflow_o.
  - Overflow_o stays set until reset.
- Dequeue:
  - out_valid_o = (count != 0); head fields are driven combinationally from the rptr entry.
  - Pop advances rptr; pointers wrap at DEPTH.
  - Simultaneous push and pop at full is legal; push sees the freed slot.
- Latency: an event enqueued at edge N is visible on out_valid_o after edge N when the queue was empty, i.e. one cycle from input to output.
- count_o = count + pushes - pop, registered. almost_full_o is registered from (DEPTH - count_o) <= AFULL_SLACK.
- Empty: out_* data holds the last head value (don't-care); only out_valid_o is meaningful.

Test Plan:
- Reset, then a single commit (pc=0x80000000, ins=0x00000013, we=1, dst=5, data=0x1234) with ready=1 -> next cycle valid=1, kind=0, seq=0, fields exact; count returns to 0 after pop.
- mip_i 0->0x800 in the same cycle as a commit -> two entries: seq0 kind=0, then seq1 kind=1 data=0x800; no further mip event while mip_i is stable.
- ready=0, 16 back-to-back commits with DEPTH=16 -> count=16, almost_full_o asserted from count=14; 17th commit dropped, overflow_o=1 sticky; draining yields seq 0..15 in order.
- Full queue: commit and pop in the same cycle -> no overflow, count stays 16.
- count=15, commit plus mip change together -> commit stored, mip deferred; after one pop, mip enqueued with the next seq.
- rst_n asserted mid-drain with 5 entries queued -> outputs 0 immediately, count 0; post-reset seq restarts at 0.

Source files
------------

// File: rtl/cosim_commit_queue.sv
// Ordered queue of commit and mip-change events feeding the Spike co-simulation checker.
// Up to two events enqueue per cycle (commit first, then mip); one dequeues per valid/ready handshake.
module cosim_commit_queue #(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned HART_ID     = 0,
  parameter int unsigned AFULL_SLACK = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       commit_valid_i,
  input  logic [63:0]                commit_pc_i,
  input  logic [31:0]                commit_ins_i,
  input  logic                       commit_we_i,
  input  logic [5:0]                 commit_dst_i,
  input  logic [63:0]                commit_data_i,
  input  logic                       commit_xcpt_i,
  input  logic [63:0]                commit_cause_i,
  input  logic [63:0]                mip_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic                       out_kind_o,
  output logic [63:0]                out_pc_o,
  output logic [31:0]                out_ins_o,
  output logic                       out_we_o,
  output logic [5:0]                 out_dst_o,
  output logic [63:0]                out_data_o,
  output logic                       out_xcpt_o,
  output logic [63:0]                out_cause_o,
  output logic [31:0]                out_seq_o,
  output logic [31:0]                out_hart_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       almost_full_o,
  output logic                       overflow_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic        kind;
    logic [63:0] pc;
    logic [31:0] ins;
    logic        we;
    logic [5:0]  dst;
    logic [63:0] data;
    logic        xcpt;
    logic [63:0] cause;
    logic [31:0] seq;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [AW-1:0] rptr, wptr, mip_ptr;
  logic [CW-1:0] count, free, count_next;
  logic [31:0]   seq, mip_seq;
  logic [63:0]   mip_shadow;
  logic          pop, mip_change, push_commit, push_mip;
  entry_t        commit_e, mip_e, head;

  always_comb begin
    pop         = (count != '0) && out_ready_i;
    free        = CW'(DEPTH) - count + CW'(pop);
    mip_change  = (mip_i != mip_shadow);
    push_commit = commit_valid_i && (free != '0);
    // A mip event that does not fit behind the commit stays pending: the shadow is untouched, so it retries.
    push_mip    = mip_change && (free >= (commit_valid_i ? CW'(2) : CW'(1)));
    mip_ptr     = wptr + AW'(push_commit);
    mip_seq     = seq + 32'(push_commit);
    count_next  = count + CW'(push_commit) + CW'(push_mip) - CW'(pop);

    commit_e       = '0;
    commit_e.pc    = commit_pc_i;
    commit_e.ins   = commit_ins_i;
    commit_e.we    = commit_we_i;
    commit_e.dst   = commit_dst_i;
    commit_e.data  = commit_data_i;
    commit_e.xcpt  = commit_xcpt_i;
    commit_e.cause = commit_cause_i;
    commit_e.seq   = seq;

    mip_e      = '0;
    mip_e.kind = 1'b1;
    mip_e.data = mip_i;
    mip_e.seq  = mip_seq;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      rptr          <= '0;
      wptr          <= '0;
      count         <= '0;
      seq           <= '0;
      mip_shadow    <= '0;
      overflow_o    <= 1'b0;
      almost_full_o <= 1'b0;
    end else begin
      if (push_commit) mem[wptr] <= commit_e;
      if (push_mip) begin
        mem[mip_ptr] <= mip_e;
        mip_shadow   <= mip_i;
      end
      wptr  <= wptr + AW'(push_commit) + AW'(push_mip);
      seq   <= seq + 32'(push_commit) + 32'(push_mip);
      if (pop) rptr <= rptr + 1'b1;
      count <= count_next;
      if (commit_valid_i && (free == '0)) overflow_o <= 1'b1;
      almost_full_o <= (CW'(DEPTH) - count_next) <= CW'(AFULL_SLACK);
    end
  end

  assign head        = mem[rptr];
  assign out_valid_o = (count != '0);
  assign out_kind_o  = head.kind;
  assign out_pc_o    = head.pc;
  assign out_ins_o   = head.ins;
  assign out_we_o    = head.we;
  assign out_dst_o   = head.dst;
  assign out_data_o  = head.data;
  assign out_xcpt_o  = head.xcpt;
  assign out_cause_o = head.cause;
  assign out_seq_o   = head.seq;
  assign out_hart_o  = 32'(HART_ID);
  assign count_o     = count;

endmodule

// File: tb/tb_cosim_commit_queue.sv
// Directed bench for cosim_commit_queue: reset, single commit, mip ordering, fill/overflow,
// push+pop at full, deferred mip, and reset mid-drain.
module tb_cosim_commit_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        commit_valid_i;
  logic [63:0] commit_pc_i;
  logic [31:0] commit_ins_i;
  logic        commit_we_i;
  logic [5:0]  commit_dst_i;
  logic [63:0] commit_data_i;
  logic        commit_xcpt_i;
  logic [63:0] commit_cause_i;
  logic [63:0] mip_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic        out_kind_o;
  logic [63:0] out_pc_o;
  logic [31:0] out_ins_o;
  logic        out_we_o;
  logic [5:0]  out_dst_o;
  logic [63:0] out_data_o;
  logic        out_xcpt_o;
  logic [63:0] out_cause_o;
  logic [31:0] out_seq_o;
  logic [31:0] out_hart_o;
  logic [4:0]  count_o;
  logic        almost_full_o;
  logic        overflow_o;

  int unsigned tests = 0;
  int unsigned failed = 0;

  cosim_commit_queue #(.DEPTH(16), .HART_ID(3), .AFULL_SLACK(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .commit_valid_i(commit_valid_i), .commit_pc_i(commit_pc_i), .commit_ins_i(commit_ins_i),
    .commit_we_i(commit_we_i), .commit_dst_i(commit_dst_i), .commit_data_i(commit_data_i),
    .commit_xcpt_i(commit_xcpt_i), .commit_cause_i(commit_cause_i), .mip_i(mip_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_kind_o(out_kind_o),
    .out_pc_o(out_pc_o), .out_ins_o(out_ins_o), .out_we_o(out_we_o), .out_dst_o(out_dst_o),
    .out_data_o(out_data_o), .out_xcpt_o(out_xcpt_o), .out_cause_o(out_cause_o),
    .out_seq_o(out_seq_o), .out_hart_o(out_hart_o), .count_o(count_o),
    .almost_full_o(almost_full_o), .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    commit_valid_i = 1'b0;
    commit_pc_i    = '0;
    commit_ins_i   = '0;
    commit_we_i    = 1'b0;
    commit_dst_i   = '0;
    commit_data_i  = '0;
    commit_xcpt_i  = 1'b0;
    commit_cause_i = '0;
    mip_i          = '0;
    out_ready_i    = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (out_valid_o !== 1'b0) begin failed++; $display("FAIL reset_valid got %0h exp 0", out_valid_o); end
    tests++; if (count_o !== 5'd0) begin failed++; $display("FAIL reset_count got %0d exp 0", count_o); end
    tests++; if (out_pc_o !== 64'd0 || out_seq_o !== 32'd0 || out_data_o !== 64'd0)
      begin failed++; $display("FAIL reset_fields got pc=%0h seq=%0h data=%0h exp 0", out_pc_o, out_seq_o, out_data_o); end
    tests++; if (out_hart_o !== 32'd3) begin failed++; $display("FAIL reset_hart got %0d exp 3", out_hart_o); end
    tests++; if (almost_full_o !== 1'b0 || overflow_o !== 1'b0)
      begin failed++; $display("FAIL reset_flags got af=%0b ovf=%0b exp 0 0", almost_full_o, overflow_o); end
  endtask

  task automatic test_single_commit();
    do_reset();
    commit_valid_i = 1'b1;
    commit_pc_i    = 64'h8000_0000;
    commit_ins_i   = 32'h0000_0013;
    commit_we_i    = 1'b1;
    commit_dst_i   = 6'd5;
    commit_data_i  = 64'h1234;
    out_ready_i    = 1'b1;
    tick();
    commit_valid_i = 1'b0;
    tests++; if (out_valid_o !== 1'b1 || out_kind_o !== 1'b0 || out_seq_o !== 32'd0)
      begin failed++; $display("FAIL single_head got v=%0b k=%0b seq=%0d exp 1 0 0", out_valid_o, out_kind_o, out_seq_o); end
    tests++; if (out_pc_o !== 64'h8000_0000 || out_ins_o !== 32'h13 || out_we_o !== 1'b1 ||
                 out_dst_o !== 6'd5 || out_data_o !== 64'h1234 || out_xcpt_o !== 1'b0 || out_cause_o !== 64'd0)
      begin failed++; $display("FAIL single_fields got pc=%0h ins=%0h we=%0b dst=%0d data=%0h exp 80000000 13 1 5 1234",
                               out_pc_o, out_ins_o, out_we_o, out_dst_o, out_data_o); end
    tests++; if (count_o !== 5'd1) begin failed++; $display("FAIL single_count1 got %0d exp 1", count_o); end
    tick();
    tests++; if (count_o !== 5'd0 || out_valid_o !== 1'b0)
      begin failed++; $display("FAIL single_drained got count=%0d v=%0b exp 0 0", count_o, out_valid_o); end
    out_ready_i = 1'b0;
  endtask

  task automatic test_mip_order();
    do_reset();
    commit_valid_i = 1'b1;
    commit_pc_i    = 64'h100;
    commit_xcpt_i  = 1'b1;
    commit_cause_i = 64'd2;
    mip_i          = 64'h800;
    tick();
    commit_valid_i = 1'b0;
    commit_xcpt_i  = 1'b0;
    tests++; if (count_o !== 5'd2) begin failed++; $display("FAIL mip_count2 got %0d exp 2", count_o); end
    tests++; if (out_kind_o !== 1'b0 || out_seq_o !== 32'd0 || out_pc_o !== 64'h100 ||
                 out_xcpt_o !== 1'b1 || out_cause_o !== 64'd2)
      begin failed++; $display("FAIL mip_first got k=%0b seq=%0d pc=%0h x=%0b c=%0d exp 0 0 100 1 2",
                               out_kind_o, out_seq_o, out_pc_o, out_xcpt_o, out_cause_o); end
    tick();
    tick();
    tests++; if (count_o !== 5'd2) begin failed++; $display("FAIL mip_stable got %0d exp 2", count_o); end
    out_ready_i = 1'b1;
    tick();
    tests++; if (out_kind_o !== 1'b1 || out_seq_o !== 32'd1 || out_data_o !== 64'h800 || out_pc_o !== 64'd0)
      begin failed++; $display("FAIL mip_second got k=%0b seq=%0d data=%0h pc=%0h exp 1 1 800 0",
                               out_kind_o, out_seq_o, out_data_o, out_pc_o); end
    tick();
    tests++; if (count_o !== 5'd0) begin failed++; $display("FAIL mip_drained got %0d exp 0", count_o); end
    out_ready_i = 1'b0;
  endtask

  task automatic test_fill_overflow();
    logic exp_af;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      commit_valid_i = 1'b1;
      commit_pc_i    = 64'h1000 + 64'(i);
      tick();
      exp_af = (i >= 13) ? 1'b1 : 1'b0;
      tests++; if (count_o !== 5'(i + 1) || almost_full_o !== exp_af)
        begin failed++; $display("FAIL fill_%0d got count=%0d af=%0b exp %0d %0b", i, count_o, almost_full_o, i + 1, exp_af); end
    end
    commit_pc_i = 64'hdead;
    tick();
    tests++; if (count_o !== 5'd16 || overflow_o !== 1'b1)
      begin failed++; $display("FAIL fill_drop got count=%0d ovf=%0b exp 16 1", count_o, overflow_o); end
    commit_valid_i = 1'b0;
    tick();
    tests++; if (overflow_o !== 1'b1) begin failed++; $display("FAIL fill_sticky got %0b exp 1", overflow_o); end
    out_ready_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tests++; if (out_valid_o !== 1'b1 || out_seq_o !== 32'(i) || out_pc_o !== 64'h1000 + 64'(i))
        begin failed++; $display("FAIL drain_%0d got v=%0b seq=%0d pc=%0h exp 1 %0d %0h",
                                 i, out_valid_o, out_seq_o, out_pc_o, i, 64'h1000 + 64'(i)); end
      tick();
    end
    tests++; if (count_o !== 5'd0 || out_valid_o !== 1'b0 || overflow_o !== 1'b1)
      begin failed++; $display("FAIL drain_end got count=%0d v=%0b ovf=%0b exp 0 0 1", count_o, out_valid_o, overflow_o); end
    out_ready_i = 1'b0;
  endtask

  task automatic test_full_push_pop();
    do_reset();
    commit_valid_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      commit_pc_i = 64'(i);
      tick();
    end
    commit_pc_i = 64'h77;
    out_ready_i = 1'b1;
    tick();
    commit_valid_i = 1'b0;
    out_ready_i    = 1'b0;
    tests++; if (count_o !== 5'd16 || overflow_o !== 1'b0 || out_seq_o !== 32'd1)
      begin failed++; $display("FAIL full_pushpop got count=%0d ovf=%0b seq=%0d exp 16 0 1", count_o, overflow_o, out_seq_o); end
  endtask

  task automatic test_mip_defer();
    do_reset();
    commit_valid_i = 1'b1;
    for (int i = 0; i < 15; i++) begin
      commit_pc_i = 64'(i);
      tick();
    end
    commit_pc_i = 64'hc0de;
    mip_i       = 64'h80;
    tick();
    commit_valid_i = 1'b0;
    tests++; if (count_o !== 5'd16 || overflow_o !== 1'b0)
      begin failed++; $display("FAIL defer_commit got count=%0d ovf=%0b exp 16 0", count_o, overflow_o); end
    tick();
    tests++; if (count_o !== 5'd16 || overflow_o !== 1'b0)
      begin failed++; $display("FAIL defer_wait got count=%0d ovf=%0b exp 16 0", count_o, overflow_o); end
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    tests++; if (count_o !== 5'd16) begin failed++; $display("FAIL defer_retry got %0d exp 16", count_o); end
    out_ready_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tests++; if (out_seq_o !== 32'(i + 1)) begin failed++; $display("FAIL defer_seq_%0d got %0d exp %0d", i, out_seq_o, i + 1); end
      if (i == 14) begin
        tests++; if (out_kind_o !== 1'b0 || out_pc_o !== 64'hc0de)
          begin failed++; $display("FAIL defer_commit_entry got k=%0b pc=%0h exp 0 c0de", out_kind_o, out_pc_o); end
      end
      if (i == 15) begin
        tests++; if (out_kind_o !== 1'b1 || out_data_o !== 64'h80)
          begin failed++; $display("FAIL defer_mip_entry got k=%0b data=%0h exp 1 80", out_kind_o, out_data_o); end
      end
      tick();
    end
    tests++; if (count_o !== 5'd0) begin failed++; $display("FAIL defer_drained got %0d exp 0", count_o); end
    out_ready_i = 1'b0;
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    commit_valid_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      commit_pc_i = 64'h200 + 64'(i);
      tick();
    end
    commit_valid_i = 1'b0;
    out_ready_i    = 1'b1;
    tick();
    tests++; if (count_o !== 5'd5 || out_seq_o !== 32'd1)
      begin failed++; $display("FAIL mid_pre got count=%0d seq=%0d exp 5 1", count_o, out_seq_o); end
    #2;
    rst_n = 1'b0;
    #1;
    tests++; if (out_valid_o !== 1'b0 || count_o !== 5'd0 || out_pc_o !== 64'd0 || out_seq_o !== 32'd0)
      begin failed++; $display("FAIL mid_reset got v=%0b count=%0d pc=%0h seq=%0d exp 0 0 0 0",
                               out_valid_o, count_o, out_pc_o, out_seq_o); end
    tests++; if (out_hart_o !== 32'd3) begin failed++; $display("FAIL mid_hart got %0d exp 3", out_hart_o); end
    tick();
    rst_n          = 1'b1;
    commit_valid_i = 1'b1;
    commit_pc_i    = 64'h55;
    tick();
    commit_valid_i = 1'b0;
    tests++; if (out_valid_o !== 1'b1 || out_seq_o !== 32'd0 || out_pc_o !== 64'h55 || count_o !== 5'd1)
      begin failed++; $display("FAIL mid_restart got v=%0b seq=%0d pc=%0h count=%0d exp 1 0 55 1",
                               out_valid_o, out_seq_o, out_pc_o, count_o); end
    out_ready_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_commit();
    test_mip_order();
    test_fill_overflow();
    test_full_push_pop();
    test_mip_defer();
    test_reset_mid_drain();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
